// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: state encoding,
// frame constants and the baud-counter width helper.
package fifo_uart_tx_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } tx_state_e;

  function automatic int baud_w(input int clks_per_bit);
    return $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, held at zero while clear is high.
// tick marks the last cycle of a bit period, tick_early the cycle before it.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic tick,
  output logic tick_early
);
  import fifo_uart_tx_pkg::*;

  localparam int W = baud_w(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] PRE  = W'(CLKS_PER_BIT - 2);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (!reset_n)
      r_cnt <= '0;
    else if (clear || r_cnt == LAST)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

  // tick_early lets the FSM register outputs that must be valid in the final cycle
  assign tick       = !clear && (r_cnt == LAST);
  assign tick_early = !clear && (r_cnt == PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 transmitter pulling bytes from a registered-read FIFO; all serial-side
// outputs come straight from flops.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tx_enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_read,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);
  import fifo_uart_tx_pkg::*;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_e            r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [2:0]           r_bit;
  logic                 r_tx;
  logic                 r_read;
  logic                 r_done;

  logic w_clear;
  logic w_tick;
  logic w_tick_early;
  logic w_can_read;

  assign w_clear    = (r_state == ST_IDLE) || (r_state == ST_FETCH);
  assign w_can_read = tx_enable && !fifo_empty;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (w_clear),
    .tick       (w_tick),
    .tick_early (w_tick_early)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
      r_read  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx   <= 1'b1;
          r_done <= 1'b0;
          // the read strobe is issued from IDLE; FETCH follows once it has been seen
          if (r_read) begin
            r_read  <= 1'b0;
            r_state <= ST_FETCH;
          end else if (w_can_read) begin
            r_read <= 1'b1;
          end
        end
        ST_FETCH: begin
          r_read  <= 1'b0;
          r_shift <= fifo_data;
          r_bit   <= '0;
          r_tx    <= 1'b0;
          r_state <= ST_START;
        end
        ST_START: begin
          if (w_tick) begin
            r_tx    <= r_shift[0];
            r_bit   <= '0;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_bit == LAST_BIT) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
              r_bit   <= r_bit + 3'd1;
            end
          end
        end
        ST_STOP: begin
          r_tx <= 1'b1;
          if (w_tick) begin
            r_done  <= 1'b0;
            r_read  <= 1'b0;
            r_state <= r_read ? ST_FETCH : ST_IDLE;
          end else if (w_tick_early) begin
            // arm strobes so they are registered in the final stop cycle
            r_done <= 1'b1;
            r_read <= w_can_read;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
          r_read  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign tx         = r_tx;
  assign fifo_read  = r_read;
  assign frame_done = r_done;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port tx_enable  input  1  permits fetching a new byte when high.
REQ-005 SHALL have port fifo_empty  input  1  upstream FIFO empty flag.
REQ-006 SHALL have port fifo_data  input  8  upstream FIFO registered read data, valid the cycle after fifo_read.
REQ-007 SHALL have port fifo_read  output  1  single-cycle read strobe to the upstream FIFO.
REQ-008 SHALL have port tx  output  1  serial line, 8N1, idle high.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse in the last cycle of each stop bit.

Function
REQ-011 SHALL implement states IDLE, FETCH, START, DATA, STOP.
REQ-012 In IDLE, with tx_enable=1 and fifo_empty=0, SHALL assert fifo_read for exactly one cycle and go to FETCH.
REQ-013 In FETCH, SHALL capture fifo_data into an 8-bit shift register and go to START; tx stays high.
REQ-014 In START, SHALL drive tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-015 In DATA, SHALL drive the 8 bits LSB first, each for CLKS_PER_BIT cycles, using a 3-bit bit index; after bit 7, SHALL go to STOP.
REQ-016 In STOP, SHALL drive tx=1 for CLKS_PER_BIT cycles and pulse frame_done in the final cycle.
REQ-017 In the final STOP cycle, with tx_enable=1 and fifo_empty=0, SHALL assert fifo_read and go directly to FETCH; otherwise it SHALL go to IDLE.
REQ-018 Latency: if fifo_read is asserted in cycle N, tx SHALL go low in cycle N+2; a full frame SHALL last 10*CLKS_PER_BIT cycles; back-to-back frames SHALL have exactly one extra idle-high cycle (FETCH).
REQ-019 The baud counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide, count 0..CLKS_PER_BIT-1, and clear on each state change.
REQ-020 fifo_empty and tx_enable SHALL be sampled only at the read decision points (IDLE, final STOP cycle); changes mid-frame SHALL NOT affect the frame in progress.
REQ-021 Deasserting tx_enable mid-frame SHALL let the current frame complete and then park the block in IDLE.
REQ-022 fifo_read SHALL never be asserted while fifo_empty=1 at the same edge, and never in two consecutive cycles.
REQ-023 tx, fifo_read and frame_done SHALL be driven from registers (glitch-free).

Reset
REQ-024 With reset_n=0 at a clock edge, the block SHALL go to IDLE with tx=1, busy=0, fifo_read=0, frame_done=0, and counters and shift register at 0.
REQ-025 Reset mid-frame SHALL abandon the frame: tx SHALL be high from the next edge, and the captured byte SHALL be discarded, not re-fetched.

Structure
REQ-026 A shared package SHALL hold the state encoding (3-bit enum) and the constant DATA_BITS=8.
REQ-027 The baud counter SHALL be a sub-module, uart_baud_tick, with inputs clock, reset_n and clear and an output tick that pulses in the last cycle of each bit period.
REQ-028 The block SHALL connect directly to the existing 8-bit, 32-deep FIFO (read/dataout/empty) with no glue logic.

Verification (CLKS_PER_BIT=4)
REQ-029 Single byte: load 8'hA5, raise tx_enable -> one fifo_read pulse; tx pattern 0,1,0,1,0,0,1,0,1,1 with 4 cycles per bit; frame_done pulses once; busy is high for 41 cycles (1 FETCH + 40 frame cycles).
REQ-030 Back-to-back: preload 8'h00 and 8'hFF -> two frames separated by exactly 1 extra high cycle; exactly 2 fifo_read pulses, then IDLE with fifo_empty=1.
REQ-031 Empty hold-off: fifo_empty=1 for 100 cycles with tx_enable=1 -> fifo_read stays 0, tx stays 1, busy stays 0.
REQ-032 Enable drop: deassert tx_enable during bit 3 of a 3-byte burst -> the current frame completes, no further fifo_read, and the 2 remaining bytes stay in the FIFO.
REQ-033 Reset mid-frame: assert reset_n=0 during DATA bit 5 -> the next cycle shows tx=1, busy=0; after release, the next byte transmits correctly from the start bit.
REQ-034 FIFO boundary: fill the FIFO with 32 bytes 0..31 -> all 32 transmit in order, fifo_empty asserts after the 32nd read, and the block stops in IDLE.
